vend_coin_arbiter: RTL and testbench

- Shares one vending_mealy coin datapath between two coin requesters, e.g. a front-panel slot and a remote/payment slot.
- Accepts coins over per-requester valid/ready handshakes.
- Serialises each coin into the FSM's one-cycle coin pulse followed by 00 idle cycles.
- Locks the FSM to one requester per purchase so credit is never mixed, and counts completed vends per requester.

---
 rtl/vend_coin_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_vend_coin_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vend_coin_arbiter.sv
// vend_coin_arbiter: lets two coin requesters share one vending_mealy
// coin datapath. Coins arrive over valid/ready handshakes. Each coin is
// replayed to the FSM as a one-cycle pulse followed by idle cycles. The
// FSM is locked to one requester per purchase, so credit from the two
// requesters is never combined. Completed vends are counted per requester.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | vm_coin=00, handshakes may complete (only state with ready)
// S_ISSUE | one cycle, vm_coin = captured coin
// S_GAP   | GAP_CYCLES cycles of vm_coin=00; the first one still samples
//         | dispense so that registered-output FSMs are covered as well
module vend_coin_arbiter #(
  parameter int GAP_CYCLES   = 1,
  parameter int LOCK_TIMEOUT = 64,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [1:0]       req0_coin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_coin,
  output logic             req1_ready,
  output logic [1:0]       vm_coin,
  input  logic             vm_dispense,
  input  logic             vm_chg5,
  output logic             owner_valid,
  output logic             owner_id,
  output logic             vend_done,
  output logic             vend_id,
  output logic             vend_chg5,
  output logic             coin_err,
  output logic             lock_timeout,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state_q;
  logic [1:0]        vm_coin_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              armed_q;
  logic              ptr_q;
  logic              owner_valid_q;
  logic              owner_id_q;
  logic              vend_done_q;
  logic              vend_id_q;
  logic              vend_chg5_q;
  logic              coin_err_q;
  logic              lock_timeout_q;
  logic [CNT_W-1:0]  cnt0_q;
  logic [CNT_W-1:0]  cnt1_q;

  logic              gnt0;
  logic              gnt1;
  logic              xfer;
  logic              xfer_id;
  logic [1:0]        xfer_coin;
  logic              coin_ok;
  logic              coin_bad;
  logic              owner_xfer;
  logic              capture;
  logic              timeout_hit;
  logic [CNT_W-1:0]  cnt0_d;
  logic [CNT_W-1:0]  cnt1_d;

  // Grant: only in IDLE; a held lock restricts the grant to its owner,
  // otherwise a tie goes to the round-robin pointer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_IDLE) begin
      if (owner_valid_q) begin
        gnt0 = req0_valid && !owner_id_q;
        gnt1 = req1_valid &&  owner_id_q;
      end else if (req0_valid && req1_valid) begin
        gnt0 = !ptr_q;
        gnt1 =  ptr_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign xfer       = gnt0 || gnt1;
  assign xfer_id    = gnt1;
  assign xfer_coin  = gnt1 ? req1_coin : req0_coin;
  assign coin_ok    = xfer && ((xfer_coin == 2'b01) || (xfer_coin == 2'b10));
  assign coin_bad   = xfer && (xfer_coin == 2'b11);
  assign owner_xfer = xfer && owner_valid_q;

  // Only the first dispense seen in ISSUE or the first GAP cycle counts.
  assign capture = vm_dispense && armed_q && owner_valid_q &&
                   ((state_q == S_ISSUE) ||
                    ((state_q == S_GAP) && (gap_cnt_q == GAP_LAST)));

  assign timeout_hit = owner_valid_q && (state_q == S_IDLE) && !owner_xfer &&
                       (to_cnt_q == TO_LAST);

  // Saturating vend counters for the current owner.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (capture && !owner_id_q && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
    if (capture &&  owner_id_q && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
  end

  // Sequencer, lock ownership, timeout and registered pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      vm_coin_q      <= 2'b00;
      gap_cnt_q      <= '0;
      to_cnt_q       <= '0;
      armed_q        <= 1'b0;
      ptr_q          <= 1'b0;
      owner_valid_q  <= 1'b0;
      owner_id_q     <= 1'b0;
      vend_done_q    <= 1'b0;
      vend_id_q      <= 1'b0;
      vend_chg5_q    <= 1'b0;
      coin_err_q     <= 1'b0;
      lock_timeout_q <= 1'b0;
      cnt0_q         <= '0;
      cnt1_q         <= '0;
    end else begin
      vend_done_q    <= 1'b0;
      coin_err_q     <= 1'b0;
      lock_timeout_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (coin_ok) begin
            state_q   <= S_ISSUE;
            vm_coin_q <= xfer_coin;
            armed_q   <= 1'b1;
            ptr_q     <= !xfer_id;
            if (!owner_valid_q) begin
              owner_valid_q <= 1'b1;
              owner_id_q    <= xfer_id;
            end
          end
        end
        S_ISSUE: begin
          state_q   <= S_GAP;
          vm_coin_q <= 2'b00;
          gap_cnt_q <= GAP_LAST;
        end
        S_GAP: begin
          if (gap_cnt_q == '0) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: begin
          state_q   <= S_IDLE;
          vm_coin_q <= 2'b00;
        end
      endcase

      if (coin_bad) coin_err_q <= 1'b1;

      if (capture) begin
        armed_q       <= 1'b0;
        vend_done_q   <= 1'b1;
        vend_id_q     <= owner_id_q;
        vend_chg5_q   <= vm_chg5;
        owner_valid_q <= 1'b0;
      end
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;

      // An owner transfer beats an expiring timeout in the same cycle.
      if (owner_xfer || capture) begin
        to_cnt_q <= '0;
      end else if (timeout_hit) begin
        lock_timeout_q <= 1'b1;
        owner_valid_q  <= 1'b0;
        to_cnt_q       <= '0;
      end else if (owner_valid_q && (state_q == S_IDLE)) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end
  end

  assign vm_coin      = vm_coin_q;
  assign owner_valid  = owner_valid_q;
  assign owner_id     = owner_id_q;
  assign vend_done    = vend_done_q;
  assign vend_id      = vend_id_q;
  assign vend_chg5    = vend_chg5_q;
  assign coin_err     = coin_err_q;
  assign lock_timeout = lock_timeout_q;
  assign cnt0         = cnt0_q;
  assign cnt1         = cnt1_q;

endmodule

// File: tb/tb_vend_coin_arbiter.sv
// Directed bench for vend_coin_arbiter (GAP_CYCLES=1, LOCK_TIMEOUT=8).
// Inputs change and outputs are sampled just after the falling edge.
module tb_vend_coin_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [1:0] req0_coin, req1_coin;
  logic       req0_ready, req1_ready;
  logic [1:0] vm_coin;
  logic       vm_dispense, vm_chg5;
  logic       owner_valid, owner_id;
  logic       vend_done, vend_id, vend_chg5;
  logic       coin_err, lock_timeout;
  logic [7:0] cnt0, cnt1;

  int n_total = 0;
  int n_bad   = 0;

  vend_coin_arbiter #(.GAP_CYCLES(1), .LOCK_TIMEOUT(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_coin(req0_coin), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_coin(req1_coin), .req1_ready(req1_ready),
    .vm_coin(vm_coin), .vm_dispense(vm_dispense), .vm_chg5(vm_chg5),
    .owner_valid(owner_valid), .owner_id(owner_id),
    .vend_done(vend_done), .vend_id(vend_id), .vend_chg5(vend_chg5),
    .coin_err(coin_err), .lock_timeout(lock_timeout),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic offer(input bit id, input logic [1:0] coin, output logic rdy);
    @(negedge clk);
    req0_valid = !id; req0_coin = id ? 2'b00 : coin;
    req1_valid = id;  req1_coin = id ? coin : 2'b00;
    vm_dispense = 1'b0; vm_chg5 = 1'b0;
    #1;
    rdy = id ? req1_ready : req0_ready;
  endtask

  task automatic idle_cyc(input logic disp, input logic chg);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_coin = 2'b00; req1_coin = 2'b00;
    vm_dispense = disp; vm_chg5 = chg;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_coin = 2'b00; req1_coin = 2'b00;
    vm_dispense = 1'b0; vm_chg5 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_coin = 2'b00; req1_coin = 2'b00;
    vm_dispense = 1'b0; vm_chg5 = 1'b0;
    #12;
    n_total++; if (vm_coin !== 2'b00) begin n_bad++; $display("FAIL reset_vm_coin got=%b exp=00", vm_coin); end
    n_total++; if (owner_valid !== 1'b0) begin n_bad++; $display("FAIL reset_owner_valid got=%b exp=0", owner_valid); end
    n_total++; if ({vend_done, coin_err, lock_timeout} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got=%b exp=000", {vend_done, coin_err, lock_timeout}); end
    n_total++; if ({cnt1, cnt0} !== 16'h0000) begin n_bad++; $display("FAIL reset_counts got=%h exp=0000", {cnt1, cnt0}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // req0: 10 then 10, dispense on the second coin (Mealy timing).
  task automatic test_single_purchase();
    logic rdy;
    offer(0, 2'b10, rdy);
    n_total++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL p1_ready1 got=%b exp=1", rdy); end
    idle_cyc(0, 0);
    n_total++; if (vm_coin !== 2'b10) begin n_bad++; $display("FAIL p1_issue1 vm_coin got=%b exp=10", vm_coin); end
    n_total++; if ({owner_valid, owner_id} !== 2'b10) begin n_bad++; $display("FAIL p1_lock got=%b exp=10", {owner_valid, owner_id}); end
    idle_cyc(0, 0);
    n_total++; if (vm_coin !== 2'b00) begin n_bad++; $display("FAIL p1_gap1 vm_coin got=%b exp=00", vm_coin); end
    offer(0, 2'b10, rdy);
    n_total++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL p1_ready2 got=%b exp=1", rdy); end
    idle_cyc(1, 0);
    n_total++; if (vm_coin !== 2'b10) begin n_bad++; $display("FAIL p1_issue2 vm_coin got=%b exp=10", vm_coin); end
    idle_cyc(0, 0);
    n_total++; if ({vend_done, vend_id, vend_chg5} !== 3'b100) begin n_bad++; $display("FAIL p1_vend got=%b exp=100", {vend_done, vend_id, vend_chg5}); end
    n_total++; if (cnt0 !== 8'd1) begin n_bad++; $display("FAIL p1_cnt0 got=%0d exp=1", cnt0); end
    n_total++; if (owner_valid !== 1'b0) begin n_bad++; $display("FAIL p1_release got=%b exp=0", owner_valid); end
    idle_cyc(0, 0);
    n_total++; if (vend_done !== 1'b0) begin n_bad++; $display("FAIL p1_vend_pulse got=%b exp=0", vend_done); end
  endtask

  // Both requesters valid; req0 wins and holds the lock for 5,5,10.
  task automatic test_contention();
    logic [1:0] seq0 [3];
    int  k, done_cyc, r1_cyc;
    logic disp_next, done_id, early;
    seq0[0] = 2'b01; seq0[1] = 2'b01; seq0[2] = 2'b10;
    k = 0; done_cyc = -1; r1_cyc = -1; disp_next = 1'b0; done_id = 1'b1; early = 1'b0;
    apply_reset();
    for (int c = 0; c < 20 && r1_cyc < 0; c++) begin
      @(negedge clk);
      req0_valid = (k < 3);
      req0_coin  = (k < 3) ? seq0[k] : 2'b00;
      req1_valid = 1'b1; req1_coin = 2'b01;
      vm_dispense = disp_next; vm_chg5 = 1'b0;
      disp_next = 1'b0;
      #1;
      if (vend_done && done_cyc < 0) begin done_cyc = c; done_id = vend_id; end
      if (req1_ready) begin
        r1_cyc = c;
        if (done_cyc < 0) early = 1'b1;
      end
      if (req0_ready) begin
        k++;
        if (k == 3) disp_next = 1'b1;
      end
    end
    idle_cyc(0, 0);
    n_total++; if (k !== 3) begin n_bad++; $display("FAIL ct_req0_coins got=%0d exp=3", k); end
    n_total++; if (early !== 1'b0) begin n_bad++; $display("FAIL ct_req1_early got=%b exp=0", early); end
    n_total++; if (done_cyc !== 8) begin n_bad++; $display("FAIL ct_vend_cycle got=%0d exp=8", done_cyc); end
    n_total++; if (done_id !== 1'b0) begin n_bad++; $display("FAIL ct_vend_id got=%b exp=0", done_id); end
    n_total++; if (r1_cyc !== 9) begin n_bad++; $display("FAIL ct_req1_grant got=%0d exp=9", r1_cyc); end
    n_total++; if ({owner_valid, owner_id} !== 2'b11) begin n_bad++; $display("FAIL ct_req1_lock got=%b exp=11", {owner_valid, owner_id}); end
  endtask

  // req1: 10,10,5 with change.
  task automatic test_req1_change();
    logic rdy;
    apply_reset();
    offer(1, 2'b10, rdy);
    n_total++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL r1_ready1 got=%b exp=1", rdy); end
    idle_cyc(0, 0);
    n_total++; if ({owner_valid, owner_id} !== 2'b11) begin n_bad++; $display("FAIL r1_lock got=%b exp=11", {owner_valid, owner_id}); end
    idle_cyc(0, 0);
    offer(1, 2'b10, rdy);
    idle_cyc(0, 0);
    idle_cyc(0, 0);
    offer(1, 2'b01, rdy);
    n_total++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL r1_ready3 got=%b exp=1", rdy); end
    idle_cyc(1, 1);
    n_total++; if (vm_coin !== 2'b01) begin n_bad++; $display("FAIL r1_issue3 vm_coin got=%b exp=01", vm_coin); end
    idle_cyc(0, 0);
    n_total++; if ({vend_done, vend_id, vend_chg5} !== 3'b111) begin n_bad++; $display("FAIL r1_vend got=%b exp=111", {vend_done, vend_id, vend_chg5}); end
    n_total++; if ({cnt1, cnt0} !== 16'h0100) begin n_bad++; $display("FAIL r1_counts got=%h exp=0100", {cnt1, cnt0}); end
    idle_cyc(0, 0);
  endtask

  // Coin 11 is accepted and discarded; coin 00 is accepted silently.
  task automatic test_bad_coin();
    logic rdy;
    offer(0, 2'b11, rdy);
    n_total++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL bc_ready got=%b exp=1", rdy); end
    idle_cyc(0, 0);
    n_total++; if ({coin_err, vm_coin, owner_valid} !== 4'b1000) begin n_bad++; $display("FAIL bc_err got=%b exp=1000", {coin_err, vm_coin, owner_valid}); end
    offer(0, 2'b00, rdy);
    n_total++; if ({rdy, coin_err} !== 2'b10) begin n_bad++; $display("FAIL bc_zero_ready got=%b exp=10", {rdy, coin_err}); end
    idle_cyc(0, 0);
    n_total++; if ({coin_err, vm_coin, owner_valid} !== 4'b0000) begin n_bad++; $display("FAIL bc_zero_quiet got=%b exp=0000", {coin_err, vm_coin, owner_valid}); end
  endtask

  // req0 sends 5 then goes quiet; req1 keeps offering a 00 coin.
  task automatic test_timeout();
    logic rdy, ov10, ov11, blocked_bad, r1_at_to, to12;
    int to_at;
    to_at = -1; ov10 = 1'b0; ov11 = 1'b1; blocked_bad = 1'b0; r1_at_to = 1'b0; to12 = 1'b1;
    offer(0, 2'b01, rdy);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      req0_valid = 1'b0; req0_coin = 2'b00;
      req1_valid = 1'b1; req1_coin = 2'b00;
      vm_dispense = 1'b0; vm_chg5 = 1'b0;
      #1;
      if (lock_timeout && to_at < 0) to_at = i;
      if (i <= 10 && req1_ready) blocked_bad = 1'b1;
      if (i == 10) ov10 = owner_valid;
      if (i == 11) begin ov11 = owner_valid; r1_at_to = req1_ready; end
      if (i == 12) to12 = lock_timeout;
    end
    idle_cyc(0, 0);
    n_total++; if (to_at !== 11) begin n_bad++; $display("FAIL to_cycle got=%0d exp=11", to_at); end
    n_total++; if ({ov10, ov11} !== 2'b10) begin n_bad++; $display("FAIL to_release got=%b exp=10", {ov10, ov11}); end
    n_total++; if (blocked_bad !== 1'b0) begin n_bad++; $display("FAIL to_req1_blocked got=%b exp=0", blocked_bad); end
    n_total++; if (r1_at_to !== 1'b1) begin n_bad++; $display("FAIL to_req1_grant got=%b exp=1", r1_at_to); end
    n_total++; if (to12 !== 1'b0) begin n_bad++; $display("FAIL to_pulse_width got=%b exp=0", to12); end
    n_total++; if ({cnt1, cnt0} !== 16'h0100) begin n_bad++; $display("FAIL to_counts got=%h exp=0100", {cnt1, cnt0}); end
  endtask

  // Reset lands in the middle of an ISSUE cycle, then a clean purchase.
  task automatic test_reset_mid_issue();
    logic rdy;
    offer(0, 2'b10, rdy);
    idle_cyc(0, 0);
    n_total++; if (vm_coin !== 2'b10) begin n_bad++; $display("FAIL rm_pre_issue got=%b exp=10", vm_coin); end
    #2;
    rst = 1'b0;
    #1;
    n_total++; if (vm_coin !== 2'b00) begin n_bad++; $display("FAIL rm_vm_coin got=%b exp=00", vm_coin); end
    n_total++; if ({owner_valid, owner_id, vend_done, coin_err, lock_timeout} !== 5'b00000) begin n_bad++; $display("FAIL rm_flags got=%b exp=00000", {owner_valid, owner_id, vend_done, coin_err, lock_timeout}); end
    n_total++; if ({cnt1, cnt0} !== 16'h0000) begin n_bad++; $display("FAIL rm_counts got=%h exp=0000", {cnt1, cnt0}); end
    @(negedge clk);
    rst = 1'b1;
    offer(0, 2'b10, rdy);
    n_total++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL rm_ready1 got=%b exp=1", rdy); end
    idle_cyc(0, 0);
    idle_cyc(0, 0);
    offer(0, 2'b10, rdy);
    idle_cyc(1, 0);
    idle_cyc(0, 0);
    n_total++; if ({vend_done, vend_id, vend_chg5} !== 3'b100) begin n_bad++; $display("FAIL rm_vend got=%b exp=100", {vend_done, vend_id, vend_chg5}); end
    n_total++; if ({cnt1, cnt0} !== 16'h0001) begin n_bad++; $display("FAIL rm_counts_after got=%h exp=0001", {cnt1, cnt0}); end
  endtask

  initial begin
    test_reset();
    test_single_purchase();
    test_contention();
    test_req1_change();
    test_bad_coin();
    test_timeout();
    test_reset_mid_issue();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
